// File: rtl/wallace_prod_accum.sv
// Streaming accumulator behind the 4x4 Wallace multiplier: sums N_TERMS products per batch.
// Optional build macro WALLACE_ACC_SATURATE_EN clamps the sum on overflow instead of wrapping.
module wallace_prod_accum #(
  parameter  int ACC_W   = 16,
  parameter  int N_TERMS = 4,
  localparam int CNT_W   = $clog2(N_TERMS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             clear,
  input  logic [7:0]       prod_in,
  input  logic             prod_valid,
  output logic             prod_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             acc_valid,
  input  logic             acc_ready,
  output logic [CNT_W-1:0] term_cnt,
  output logic             ovf
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_HOLD} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             accept;
  logic [ACC_W:0]   sum;

  assign prod_ready = (state_q == S_ACCUM) & ena;
  assign accept     = prod_valid & prod_ready;
  assign sum        = {1'b0, acc_q} + {{(ACC_W - 7){1'b0}}, prod_in};

  assign acc_out   = acc_q;
  assign acc_valid = valid_q;
  assign term_cnt  = cnt_q;
  assign ovf       = ovf_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    if (ena) begin
      if (clear) begin
        // Abort wins over any handshake offered in the same cycle.
        state_d = S_ACCUM;
        acc_d   = '0;
        cnt_d   = '0;
        valid_d = 1'b0;
        ovf_d   = 1'b0;
      end else begin
        case (state_q)
          S_IDLE: state_d = S_ACCUM;
          S_ACCUM: begin
            if (accept) begin
              cnt_d = cnt_q + CNT_W'(1);
              ovf_d = ovf_q | sum[ACC_W];
`ifdef WALLACE_ACC_SATURATE_EN
              // Once clamped, the batch stays pinned at full scale.
              acc_d = (ovf_q | sum[ACC_W]) ? '1 : sum[ACC_W-1:0];
`else
              acc_d = sum[ACC_W-1:0];
`endif
              if (cnt_q == LAST_CNT) begin
                state_d = S_HOLD;
                valid_d = 1'b1;
              end
            end
          end
          S_HOLD: begin
            if (acc_ready) begin
              state_d = S_ACCUM;
              acc_d   = '0;
              cnt_d   = '0;
              valid_d = 1'b0;
              ovf_d   = 1'b0;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule
